// File: rtl/stft_frame_buffer.sv
// Serial-to-frame assembler feeding the 4-point FFT stage of the STFT path.
// Samples arrive one per handshake. Every HOP samples, once four samples have
// been collected, the last four are presented as one frame on eight registered
// words that hold until the consumer takes them.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clear               restart framing (partial window and pending frame dropped)
//   s_valid/s_ready     input sample handshake (s_ready is combinational)
//   s_re, s_im          input sample, real / imaginary
//   m_valid/m_ready     output frame handshake
//   re_x0..re_x3        frame real words, x0 oldest .. x3 newest
//   im_x0..im_x3        frame imaginary words
//   frame_idx           index of the frame on the outputs (first frame is 0)
//   overrun             sticky flag: a sample was offered while s_ready was low
module stft_frame_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned HOP    = 2,
    parameter int unsigned IDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_re,
    input  logic [DATA_W-1:0] s_im,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] re_x0,
    output logic [DATA_W-1:0] re_x1,
    output logic [DATA_W-1:0] re_x2,
    output logic [DATA_W-1:0] re_x3,
    output logic [DATA_W-1:0] im_x0,
    output logic [DATA_W-1:0] im_x1,
    output logic [DATA_W-1:0] im_x2,
    output logic [DATA_W-1:0] im_x3,
    output logic [IDX_W-1:0]  frame_idx,
    output logic              overrun
);

    // Counters must reach 4 (fill) and HOP <= 4 (hop).
    localparam int unsigned CNT_W = 3;

    generate
        if (HOP != 1 && HOP != 2 && HOP != 4) begin : g_bad_hop
            $error("stft_frame_buffer: HOP must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic {
        ST_FILL,
        ST_STEADY
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]         hop_cnt_q, hop_cnt_d;
    logic [3:0][DATA_W-1:0]   win_re_q, win_im_q;
    logic [3:0][DATA_W-1:0]   out_re_q, out_im_q;
    logic                     first_done_q;
    logic                     in_xfer_c;
    logic                     out_xfer_c;
    logic                     load_c;

    // Handshakes
    assign s_ready    = rst_n & ~clear & (~m_valid | m_ready);
    assign in_xfer_c  = s_valid & s_ready;
    assign out_xfer_c = m_valid & m_ready;

    assign re_x0 = out_re_q[0];
    assign re_x1 = out_re_q[1];
    assign re_x2 = out_re_q[2];
    assign re_x3 = out_re_q[3];
    assign im_x0 = out_im_q[0];
    assign im_x1 = out_im_q[1];
    assign im_x2 = out_im_q[2];
    assign im_x3 = out_im_q[3];

    // Next-state: decide when the accepted sample completes a frame
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        hop_cnt_d  = hop_cnt_q;
        load_c     = 1'b0;
        if (clear) begin
            state_d    = ST_FILL;
            fill_cnt_d = '0;
            hop_cnt_d  = '0;
        end else if (in_xfer_c) begin
            case (state_q)
                ST_FILL: begin
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                    if (fill_cnt_q == CNT_W'(3)) begin
                        load_c    = 1'b1;
                        state_d   = ST_STEADY;
                        hop_cnt_d = '0;
                    end
                end
                ST_STEADY: begin
                    if (hop_cnt_q == CNT_W'(HOP - 1)) begin
                        load_c    = 1'b1;
                        hop_cnt_d = '0;
                    end else begin
                        hop_cnt_d = hop_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    // State, window shift register and registered frame outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            fill_cnt_q   <= '0;
            hop_cnt_q    <= '0;
            win_re_q     <= '0;
            win_im_q     <= '0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            m_valid      <= 1'b0;
            frame_idx    <= '0;
            first_done_q <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            hop_cnt_q  <= hop_cnt_d;

            if (s_valid && !s_ready) begin
                overrun <= 1'b1;
            end

            // Newest sample enters at index 3, oldest falls out of index 0
            if (in_xfer_c) begin
                win_re_q <= {s_re, win_re_q[3:1]};
                win_im_q <= {s_im, win_im_q[3:1]};
            end

            if (clear) begin
                m_valid <= 1'b0;
            end else if (load_c) begin
                out_re_q     <= {s_re, win_re_q[3:1]};
                out_im_q     <= {s_im, win_im_q[3:1]};
                m_valid      <= 1'b1;
                first_done_q <= 1'b1;
                if (first_done_q) begin
                    frame_idx <= frame_idx + IDX_W'(1);
                end
            end else if (out_xfer_c) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
